// File: rtl/sensor_text_formatter_if.sv
// Reading handshake between a sensor front-end (master) and sensor_text_formatter (slave).
//   valid : master holds a reading
//   ready : slave can accept (a transfer is valid & ready at a rising clock edge)
//   ch    : target channel / text line
//   value : unsigned binary reading
interface sensor_text_formatter_if #(
  parameter int unsigned CH_W  = 1,
  parameter int unsigned VAL_W = 16
);
  logic             valid;
  logic             ready;
  logic [CH_W-1:0]  ch;
  logic [VAL_W-1:0] value;

  modport master (output valid, output ch, output value, input ready);
  modport slave  (input valid, input ch, input value, output ready);
endinterface

// File: rtl/sensor_text_formatter.sv
// sensor_text_formatter: converts binary readings to decimal with a sequential double-dabble
// engine and rewrites the target channel's fixed-width ASCII line as "label=digits unit".
// Ports:
//   i_clk   clock
//   i_rst   asynchronous, active-high reset
//   bus     slave side of the reading handshake (valid/ready/ch/value)
//   o_done  one-cycle pulse after a line has been rewritten
//   o_ovf   per-channel flag: last accepted value >= 10**DIGITS
//   o_txt   channel k line at [k*COLS*8 +: COLS*8], column 0 in the MSB byte
// Optional build macro FMT_LZ_BLANK_EN: blank leading zero digits (last digit always shown).
module sensor_text_formatter #(
  parameter int unsigned        N_CH   = 2,
  parameter int unsigned        VAL_W  = 16,
  parameter int unsigned        DIGITS = 3,
  parameter int unsigned        COLS   = 16,
  parameter logic [N_CH*32-1:0] LABELS = {"HUM ", "TEMP"},
  parameter logic [N_CH*8-1:0]  UNITS  = {"%", "C"},
  localparam int unsigned       CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  sensor_text_formatter_if.slave bus,
  output logic                   o_done,
  output logic [N_CH-1:0]        o_ovf,
  output logic [N_CH*COLS*8-1:0] o_txt
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(VAL_W + 1);
  localparam logic [63:0] LIMIT = 64'(10 ** DIGITS);

  typedef enum logic [1:0] {StIdle, StConv, StWrite} state_e;

  state_e             r_state, w_state_next;
  logic [CH_W-1:0]    r_ch;
  logic [VAL_W-1:0]   r_val;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_cur;
  logic [COLS*8-1:0]  r_txt [N_CH];
  logic [N_CH-1:0]    r_ovf;
  logic               r_done;

  logic               w_accept;
  logic               w_ch_ok;
  logic               w_ovf_in;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [BCD_W-1:0]   w_bcd_shift;
  logic [31:0]        w_label;
  logic [7:0]         w_unit;
  logic [3:0]         w_nib;
  logic [COLS*8-1:0]  w_line;
`ifdef FMT_LZ_BLANK_EN
  logic               w_lead;
`endif

  assign bus.ready = (r_state == StIdle);
  assign w_accept  = bus.valid && (r_state == StIdle);
  // Out-of-range channels are accepted and dropped without leaving IDLE.
  assign w_ch_ok   = (32'(bus.ch) < N_CH);
  assign w_ovf_in  = (64'(bus.value) >= LIMIT);
  assign w_label   = LABELS[32'(r_ch) * 32 +: 32];
  assign w_unit    = UNITS[32'(r_ch) * 8 +: 8];

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept && w_ch_ok) w_state_next = StConv;
      StConv:  if (r_cnt == CNT_W'(1)) w_state_next = StWrite;
      StWrite: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the value MSB.
  // Carries out of the top nibble only occur on overflow, where digits are unused.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
    w_bcd_shift = (w_bcd_adj << 1) | BCD_W'(r_val[VAL_W-1]);
  end

  // Formatted line for the captured channel.
  always_comb begin
    w_line = {COLS{8'h20}};
    w_nib  = '0;
`ifdef FMT_LZ_BLANK_EN
    w_lead = 1'b1;
`endif
    for (int c = 0; c < 4; c++) begin
      w_line[(int'(COLS) - 1 - c) * 8 +: 8] = w_label[(3 - c) * 8 +: 8];
    end
    w_line[(COLS - 5) * 8 +: 8] = 8'h3D;
    for (int d = 0; d < int'(DIGITS); d++) begin
      w_nib = r_bcd[(int'(DIGITS) - 1 - d) * 4 +: 4];
      if (r_ovf_cur) begin
        w_line[(int'(COLS) - 6 - d) * 8 +: 8] = 8'h2D;
      end
`ifdef FMT_LZ_BLANK_EN
      else if (w_lead && (w_nib == 4'd0) && (d < int'(DIGITS) - 1)) begin
        w_line[(int'(COLS) - 6 - d) * 8 +: 8] = 8'h20;
      end else begin
        w_line[(int'(COLS) - 6 - d) * 8 +: 8] = {4'h3, w_nib};
        w_lead = 1'b0;
      end
`else
      else begin
        w_line[(int'(COLS) - 6 - d) * 8 +: 8] = {4'h3, w_nib};
      end
`endif
    end
    w_line[(COLS - 7 - DIGITS) * 8 +: 8] = w_unit;
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ch      <= '0;
      r_val     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_ovf_cur <= 1'b0;
      r_ovf     <= '0;
      r_done    <= 1'b0;
      for (int k = 0; k < int'(N_CH); k++) r_txt[k] <= {COLS{8'h20}};
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept && w_ch_ok) begin
            r_ch      <= bus.ch;
            r_val     <= bus.value;
            r_ovf_cur <= w_ovf_in;
            r_bcd     <= '0;
            r_cnt     <= CNT_W'(VAL_W);
          end
        end
        StConv: begin
          r_bcd <= w_bcd_shift;
          r_val <= r_val << 1;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        StWrite: begin
          r_txt[r_ch] <= w_line;
          r_ovf[r_ch] <= r_ovf_cur;
          r_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_txt
    assign o_txt[k*COLS*8 +: COLS*8] = r_txt[k];
  end

  assign o_ovf  = r_ovf;
  assign o_done = r_done;

endmodule

// File: tb/tb_sensor_text_formatter.sv
// Self-checking bench for sensor_text_formatter: directed readings, expected lines pushed into
// a scoreboard queue by the driver and compared by a monitor on every o_done pulse.
module tb_sensor_text_formatter;

  localparam int unsigned VAL_W = 16;
  localparam int unsigned COLS  = 16;
  localparam int unsigned LW    = COLS * 8;
  localparam logic [LW-1:0] BLANK = {COLS{8'h20}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default two-channel instance
  sensor_text_formatter_if #(.CH_W(1), .VAL_W(VAL_W)) bus ();
  logic            done;
  logic [1:0]      ovf;
  logic [2*LW-1:0] txt;

  sensor_text_formatter dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus    (bus),
    .o_done (done),
    .o_ovf  (ovf),
    .o_txt  (txt)
  );

  // Three-channel instance, for an out-of-range channel on a 2-bit ch
  sensor_text_formatter_if #(.CH_W(2), .VAL_W(VAL_W)) bus3 ();
  logic            done3;
  logic [2:0]      ovf3;
  logic [3*LW-1:0] txt3;

  sensor_text_formatter #(
    .N_CH   (3),
    .LABELS ({"C2  ", "HUM ", "TEMP"}),
    .UNITS  ({"X", "%", "C"})
  ) dut3 (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus    (bus3),
    .o_done (done3),
    .o_ovf  (ovf3),
    .o_txt  (txt3)
  );

  typedef struct packed {
    logic [2*LW-1:0] txt;
    logic [1:0]      ovf;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  logic [LW-1:0] exp_line [2];
  logic [1:0]    exp_ovf;
  int            checks = 0;
  int            fails  = 0;
  int            done3_cnt = 0;

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every o_done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got o_done=1 want no pending line");
      end else begin
        mon_e = sb_q.pop_front();
        check("line_txt", 384'(txt), 384'(mon_e.txt));
        check("ovf_flags", 384'(ovf), 384'(mon_e.ovf));
      end
    end
    if (!rst && done3) done3_cnt++;
  end

  task automatic expect_line(input int ch, input logic [LW-1:0] line, input logic ov);
    exp_line[ch] = line;
    exp_ovf[ch]  = ov;
    sb_q.push_back('{txt: {exp_line[1], exp_line[0]}, ovf: exp_ovf});
  endtask

  // Present a reading and hold it until accepted; returns cycles spent waiting for ready.
  task automatic xfer(input int ch, input int val, output int waited);
    bus.valid = 1'b1;
    bus.ch    = ch[0];
    bus.value = val[15:0];
    waited    = 0;
    while (!bus.ready && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!bus.ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got ready=0 want ready=1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
  endtask

  // Called just after acceptance: ready must return VAL_W+1 edges later, together with o_done.
  task automatic wait_idle();
    int n = 0;
    while (!bus.ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 384'(n), 384'(VAL_W + 1));
    check("done_with_ready", 384'(done), 384'(1));
  endtask

  task automatic run(input int ch, input int val, input logic [LW-1:0] line, input logic ov);
    int w;
    expect_line(ch, line, ov);
    xfer(ch, val, w);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before timeout");
    $fatal(1);
  end

  initial begin
    int w;
    rst        = 1'b1;
    bus.valid  = 1'b0;
    bus.ch     = '0;
    bus.value  = '0;
    bus3.valid = 1'b0;
    bus3.ch    = '0;
    bus3.value = '0;
    exp_line[0] = BLANK;
    exp_line[1] = BLANK;
    exp_ovf     = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_txt", 384'(txt), 384'({BLANK, BLANK}));
    check("reset_ready", 384'(bus.ready), 384'(1));
    check("reset_ovf", 384'(ovf), 384'(0));
    check("reset_done", 384'(done), 384'(0));

    run(0, 25, "TEMP=025 C      ", 1'b0);
    run(1, 999, "HUM =999 %      ", 1'b0);
    run(1, 1000, "HUM =--- %      ", 1'b1);
`ifdef FMT_LZ_BLANK_EN
    run(1, 7, "HUM =  7 %      ", 1'b0);
`else
    run(1, 7, "HUM =007 %      ", 1'b0);
`endif

    // Second reading held valid during the first conversion.
`ifdef FMT_LZ_BLANK_EN
    expect_line(1, "HUM = 12 %      ", 1'b0);
`else
    expect_line(1, "HUM =012 %      ", 1'b0);
`endif
    xfer(1, 12, w);
`ifdef FMT_LZ_BLANK_EN
    expect_line(0, "TEMP= 50 C      ", 1'b0);
`else
    expect_line(0, "TEMP=050 C      ", 1'b0);
`endif
    xfer(0, 50, w);
    check("busy_hold_wait", 384'(w), 384'(VAL_W + 1));
    wait_idle();

`ifdef FMT_LZ_BLANK_EN
    run(0, 5, "TEMP=  5 C      ", 1'b0);
    run(0, 0, "TEMP=  0 C      ", 1'b0);
`else
    run(0, 5, "TEMP=005 C      ", 1'b0);
    run(0, 0, "TEMP=000 C      ", 1'b0);
`endif
    run(0, 100, "TEMP=100 C      ", 1'b0);
    run(0, 65535, "TEMP=--- C      ", 1'b1);

    // Reset in the middle of a conversion drops the reading.
    xfer(0, 77, w);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_txt", 384'(txt), 384'({BLANK, BLANK}));
    check("midrst_ready", 384'(bus.ready), 384'(1));
    check("midrst_ovf", 384'(ovf), 384'(0));
    check("midrst_done", 384'(done), 384'(0));
    exp_line[0] = BLANK;
    exp_line[1] = BLANK;
    exp_ovf     = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    run(0, 42, "TEMP=042 C      ", 1'b0);

    // Three-channel build: ch 3 is accepted and discarded.
    bus3.valid = 1'b1;
    bus3.ch    = 2'd3;
    bus3.value = 16'd5;
    @(posedge clk);
    #1;
    bus3.valid = 1'b0;
    check("discard_ready", 384'(bus3.ready), 384'(1));
    repeat (20) @(posedge clk);
    #1;
    check("discard_done", 384'(done3_cnt), 384'(0));
    check("discard_txt", 384'(txt3), 384'({BLANK, BLANK, BLANK}));

    bus3.valid = 1'b1;
    bus3.ch    = 2'd2;
    bus3.value = 16'd9;
    @(posedge clk);
    #1;
    bus3.valid = 1'b0;
    repeat (VAL_W + 2) @(posedge clk);
    #1;
    check("ch2_done", 384'(done3_cnt), 384'(1));
`ifdef FMT_LZ_BLANK_EN
    check("ch2_txt", 384'(txt3), 384'({"C2  =  9 X      ", BLANK, BLANK}));
`else
    check("ch2_txt", 384'(txt3), 384'({"C2  =009 X      ", BLANK, BLANK}));
`endif

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 384'(sb_q.size()), 384'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
